// File: rtl/erm16_bus_unit.sv
// erm16_bus_unit: CPU bus bridge; cpu_* handshake in, mem_* strobes with TIMEOUT abort (bus_err), io_* port with io_stb, irq_in -> pending -> INTA vector on cpu_di
module erm16_bus_unit #(
  parameter int TIMEOUT = 8,
  parameter logic [15:0] IRQ_BASE = 16'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_do,
  input  logic        cpu_wrmem,
  input  logic        cpu_ioe,
  input  logic        cpu_req,
  input  logic        cpu_intreq,
  output logic [15:0] cpu_di,
  output logic        cpu_ready,
  output logic        cpu_irq,
  output logic        bus_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic        io_stb,
  input  logic [3:0]  irq_in
);
  typedef enum logic [2:0] {S_IDLE, S_MEM, S_IO, S_INTA, S_DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [15:0] di_q, di_d, addr_q, addr_d, wdata_q, wdata_d, io_out_q, io_out_d, dat_q, dat_d;
  logic re_q, re_d, we_q, we_d, wr_q, wr_d, rdy_q, rdy_d, err_q, err_d, stb_q, stb_d, irq_q;
  logic [3:0] pend_q, pend_d, clr;
  logic [1:0] n;
  logic hit;
  always_comb begin
    hit = |pend_q;
    n = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3;
    state_d = state_q;
    cnt_d = cnt_q;
    di_d = di_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    io_out_d = io_out_q;
    dat_d = dat_q;
    re_d = re_q;
    we_d = we_q;
    wr_d = wr_q;
    rdy_d = 1'b0;
    err_d = 1'b0;
    stb_d = 1'b0;
    clr = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (cpu_intreq) state_d = S_INTA;
        else if (cpu_req) begin
          state_d = cpu_ioe ? S_IO : S_MEM;
          wr_d = cpu_wrmem;
          dat_d = cpu_do;
          if (!cpu_ioe) begin
            addr_d = cpu_addr;
            wdata_d = cpu_do;
            re_d = ~cpu_wrmem;
            we_d = cpu_wrmem;
            cnt_d = 8'd0;
          end
        end
      end
      S_MEM: begin
        if (mem_ack || cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          re_d = 1'b0;
          we_d = 1'b0;
          rdy_d = 1'b1;
          err_d = !mem_ack;
          di_d = !mem_ack ? 16'hFFFF : re_q ? mem_rdata : di_q;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_IO: begin
        state_d = S_DONE;
        rdy_d = 1'b1;
        stb_d = wr_q;
        io_out_d = wr_q ? dat_q : io_out_q;
        di_d = wr_q ? di_q : io_in;
      end
      S_INTA: begin
        state_d = S_DONE;
        rdy_d = 1'b1;
        di_d = hit ? IRQ_BASE + {12'd0, n, 2'b00} : 16'h0000;
        clr = hit ? 4'b0001 << n : 4'b0000;
      end
      default: state_d = S_IDLE;
    endcase
    pend_d = (pend_q & ~clr) | irq_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      di_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      io_out_q <= '0;
      dat_q <= '0;
      re_q <= 1'b0;
      we_q <= 1'b0;
      wr_q <= 1'b0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      stb_q <= 1'b0;
      irq_q <= 1'b0;
      pend_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      di_q <= di_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      io_out_q <= io_out_d;
      dat_q <= dat_d;
      re_q <= re_d;
      we_q <= we_d;
      wr_q <= wr_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
      stb_q <= stb_d;
      irq_q <= |pend_d;
      pend_q <= pend_d;
    end
  end
  assign cpu_di = di_q;
  assign cpu_ready = rdy_q;
  assign cpu_irq = irq_q;
  assign bus_err = err_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re = re_q;
  assign mem_we = we_q;
  assign io_out = io_out_q;
  assign io_stb = stb_q;
endmodule

// File: tb/tb_erm16_bus_unit.sv
// tb_erm16_bus_unit: directed self-checking bench for erm16_bus_unit
module tb_erm16_bus_unit;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] cpu_addr, cpu_do, mem_rdata, io_in;
  logic cpu_wrmem, cpu_ioe, cpu_req, cpu_intreq, mem_ack;
  logic [3:0] irq_in;
  logic [15:0] cpu_di, mem_addr, mem_wdata, io_out;
  logic cpu_ready, cpu_irq, bus_err, mem_re, mem_we, io_stb;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  erm16_bus_unit dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_do(cpu_do), .cpu_wrmem(cpu_wrmem),
    .cpu_ioe(cpu_ioe), .cpu_req(cpu_req), .cpu_intreq(cpu_intreq), .cpu_di(cpu_di),
    .cpu_ready(cpu_ready), .cpu_irq(cpu_irq), .bus_err(bus_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .io_in(io_in), .io_out(io_out), .io_stb(io_stb), .irq_in(irq_in)
  );
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (cpu_di !== 16'h0000) begin n_bad++; $display("FAIL reset_di got %h exp 0000", cpu_di); end
    n_cmp++; if ({cpu_ready, cpu_irq, bus_err, mem_re, mem_we, io_stb} !== 6'b0) begin n_bad++; $display("FAIL reset_flags got %b exp 000000", {cpu_ready, cpu_irq, bus_err, mem_re, mem_we, io_stb}); end
    n_cmp++; if ({mem_addr, mem_wdata, io_out} !== 48'h0) begin n_bad++; $display("FAIL reset_regs got %h exp 0", {mem_addr, mem_wdata, io_out}); end
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    tick();
    n_cmp++; if ({cpu_di, cpu_ready, mem_re} !== 18'h0) begin n_bad++; $display("FAIL stray_ack got di=%h rdy=%b re=%b exp 0", cpu_di, cpu_ready, mem_re); end
  endtask
  task automatic test_mem_read;
    cpu_req = 1'b1; cpu_addr = 16'h0040; cpu_wrmem = 1'b0; cpu_ioe = 1'b0;
    tick();
    n_cmp++; if ({mem_re, mem_we, mem_addr} !== {2'b10, 16'h0040}) begin n_bad++; $display("FAIL rd_strobe got re=%b we=%b a=%h exp 1 0 0040", mem_re, mem_we, mem_addr); end
    tick();
    n_cmp++; if ({mem_re, cpu_ready} !== 2'b10) begin n_bad++; $display("FAIL rd_hold got re=%b rdy=%b exp 1 0", mem_re, cpu_ready); end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if ({mem_re, cpu_ready, bus_err, cpu_di} !== {3'b010, 16'hBEEF}) begin n_bad++; $display("FAIL rd_done got re=%b rdy=%b err=%b di=%h exp 0 1 0 BEEF", mem_re, cpu_ready, bus_err, cpu_di); end
    cpu_req = 1'b0;
    tick();
    n_cmp++; if ({cpu_ready, cpu_di} !== {1'b0, 16'hBEEF}) begin n_bad++; $display("FAIL rd_pulse got rdy=%b di=%h exp 0 BEEF", cpu_ready, cpu_di); end
  endtask
  task automatic test_timeout;
    int bad = 0;
    cpu_req = 1'b1; cpu_addr = 16'h0080; cpu_do = 16'h5555; cpu_wrmem = 1'b1; cpu_ioe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if ({mem_we, mem_re, cpu_ready, bus_err} !== 4'b1000) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL to_we_hold got %0d bad cycles exp 0", bad); end
    n_cmp++; if ({mem_addr, mem_wdata} !== {16'h0080, 16'h5555}) begin n_bad++; $display("FAIL to_addr got %h exp 00805555", {mem_addr, mem_wdata}); end
    tick();
    n_cmp++; if ({mem_we, cpu_ready, bus_err, cpu_di} !== {3'b011, 16'hFFFF}) begin n_bad++; $display("FAIL to_abort got we=%b rdy=%b err=%b di=%h exp 0 1 1 FFFF", mem_we, cpu_ready, bus_err, cpu_di); end
    cpu_req = 1'b0;
    tick();
    n_cmp++; if ({cpu_ready, bus_err} !== 2'b00) begin n_bad++; $display("FAIL to_pulse got rdy=%b err=%b exp 0 0", cpu_ready, bus_err); end
  endtask
  task automatic test_timeout_boundary;
    cpu_req = 1'b1; cpu_addr = 16'h0044; cpu_wrmem = 1'b0; cpu_ioe = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++; if ({mem_re, cpu_ready} !== 2'b10) begin n_bad++; $display("FAIL tb_last got re=%b rdy=%b exp 1 0", mem_re, cpu_ready); end
    mem_ack = 1'b1; mem_rdata = 16'h1357;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if ({mem_re, cpu_ready, bus_err, cpu_di} !== {3'b010, 16'h1357}) begin n_bad++; $display("FAIL tb_ack got re=%b rdy=%b err=%b di=%h exp 0 1 0 1357", mem_re, cpu_ready, bus_err, cpu_di); end
    cpu_req = 1'b0;
    tick();
  endtask
  task automatic test_io;
    cpu_req = 1'b1; cpu_ioe = 1'b1; cpu_wrmem = 1'b1; cpu_do = 16'h1234; cpu_addr = 16'hFFFF;
    tick();
    n_cmp++; if ({io_stb, cpu_ready, mem_we, mem_re} !== 4'b0000) begin n_bad++; $display("FAIL io_wr_wait got stb=%b rdy=%b we=%b re=%b exp 0000", io_stb, cpu_ready, mem_we, mem_re); end
    tick();
    n_cmp++; if ({io_stb, cpu_ready, io_out, cpu_di} !== {2'b11, 16'h1234, 16'h1357}) begin n_bad++; $display("FAIL io_wr got stb=%b rdy=%b out=%h di=%h exp 1 1 1234 1357", io_stb, cpu_ready, io_out, cpu_di); end
    cpu_req = 1'b0;
    tick();
    n_cmp++; if ({io_stb, cpu_ready} !== 2'b00) begin n_bad++; $display("FAIL io_stb_pulse got stb=%b rdy=%b exp 0 0", io_stb, cpu_ready); end
    cpu_req = 1'b1; cpu_wrmem = 1'b0; io_in = 16'h00A5; cpu_do = 16'h9999;
    tick();
    tick();
    n_cmp++; if ({io_stb, cpu_ready, cpu_di, io_out} !== {2'b01, 16'h00A5, 16'h1234}) begin n_bad++; $display("FAIL io_rd got stb=%b rdy=%b di=%h out=%h exp 0 1 00A5 1234", io_stb, cpu_ready, cpu_di, io_out); end
    cpu_req = 1'b0; cpu_ioe = 1'b0;
    tick();
  endtask
  task automatic test_irq;
    logic [15:0] vec [3];
    logic irq_after [3];
    vec[0] = 16'h0024; vec[1] = 16'h002C; vec[2] = 16'h0000;
    irq_after[0] = 1'b1; irq_after[1] = 1'b0; irq_after[2] = 1'b0;
    irq_in = 4'b1010;
    tick();
    irq_in = 4'b0000;
    n_cmp++; if (cpu_irq !== 1'b1) begin n_bad++; $display("FAIL irq_raise got %b exp 1", cpu_irq); end
    for (int i = 0; i < 3; i++) begin
      cpu_intreq = 1'b1;
      tick();
      n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL inta%0d_wait got rdy=%b exp 0", i, cpu_ready); end
      tick();
      n_cmp++; if ({cpu_ready, cpu_di, cpu_irq} !== {1'b1, vec[i], irq_after[i]}) begin n_bad++; $display("FAIL inta%0d got rdy=%b di=%h irq=%b exp 1 %h %b", i, cpu_ready, cpu_di, cpu_irq, vec[i], irq_after[i]); end
      cpu_intreq = 1'b0;
      tick();
    end
  endtask
  task automatic test_priority;
    cpu_req = 1'b1; cpu_intreq = 1'b1; cpu_addr = 16'h0100; cpu_wrmem = 1'b0; cpu_ioe = 1'b0;
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    n_cmp++; if (mem_re !== 1'b0) begin n_bad++; $display("FAIL pri_no_mem got re=%b exp 0", mem_re); end
    tick();
    n_cmp++; if ({cpu_ready, cpu_di, mem_re} !== {1'b1, 16'h0028, 1'b0}) begin n_bad++; $display("FAIL pri_inta got rdy=%b di=%h re=%b exp 1 0028 0", cpu_ready, cpu_di, mem_re); end
    cpu_intreq = 1'b0;
    tick();
    n_cmp++; if ({cpu_ready, mem_re} !== 2'b00) begin n_bad++; $display("FAIL pri_gap got rdy=%b re=%b exp 0 0", cpu_ready, mem_re); end
    tick();
    n_cmp++; if ({mem_re, mem_addr, cpu_ready} !== {1'b1, 16'h0100, 1'b0}) begin n_bad++; $display("FAIL pri_mem got re=%b a=%h rdy=%b exp 1 0100 0", mem_re, mem_addr, cpu_ready); end
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if ({cpu_ready, cpu_di, mem_re} !== {1'b1, 16'h7777, 1'b0}) begin n_bad++; $display("FAIL pri_mem_done got rdy=%b di=%h re=%b exp 1 7777 0", cpu_ready, cpu_di, mem_re); end
    cpu_req = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid;
    int bad = 0;
    cpu_req = 1'b1; cpu_addr = 16'h0200; cpu_do = 16'hAAAA; cpu_wrmem = 1'b1; cpu_ioe = 1'b0;
    tick();
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rstm_we got %b exp 1", mem_we); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_req = 1'b0;
    n_cmp++; if ({mem_we, mem_re, cpu_ready, bus_err, cpu_di, io_out} !== 36'h0) begin n_bad++; $display("FAIL rstm_clear got we=%b re=%b rdy=%b err=%b di=%h out=%h exp all 0", mem_we, mem_re, cpu_ready, bus_err, cpu_di, io_out); end
    for (int i = 0; i < 12; i++) begin
      tick();
      if ({cpu_ready, bus_err, mem_we} !== 3'b000) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rstm_quiet got %0d bad cycles exp 0", bad); end
  endtask
  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_do = '0; cpu_wrmem = 1'b0; cpu_ioe = 1'b0; cpu_req = 1'b0;
    cpu_intreq = 1'b0; mem_rdata = '0; mem_ack = 1'b0; io_in = '0; irq_in = '0;
    test_reset();
    test_mem_read();
    test_timeout();
    test_timeout_boundary();
    test_io();
    test_irq();
    test_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/erm16_bus_unit.md
ERM16_BUS_UNIT -- requirements
Module: erm16_bus_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, max cycles waiting for mem_ack before abort (legal 1..255).
REQ-002 SHALL have parameter IRQ_BASE, default 16'h0020, base interrupt vector address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cpu_addr  input  16  address from CPU ADDR_BUS.
REQ-006 cpu_do  input  16  write data from CPU DO.
REQ-007 cpu_wrmem  input  1  1 = write, 0 = read; sampled at acceptance.
REQ-008 cpu_ioe  input  1  1 = IO space, 0 = memory space; sampled at acceptance.
REQ-009 cpu_req  input  1  level transfer request, held by CPU until cpu_ready.
REQ-010 cpu_intreq  input  1  interrupt-acknowledge request from CPU.
REQ-011 cpu_di  output  16  read data / vector to CPU DI, registered.
REQ-012 cpu_ready  output  1  one-cycle completion pulse.
REQ-013 cpu_irq  output  1  OR of pending interrupt bits, registered.
REQ-014 bus_err  output  1  one-cycle pulse on memory timeout.
REQ-015 mem_addr / mem_wdata  output  16 each  memory address / write data, registered.
REQ-016 mem_re / mem_we  output  1 each  memory read / write strobes, level until ack or abort.
REQ-017 mem_rdata  input  16  memory read data, valid when mem_ack=1.
REQ-018 mem_ack  input  1  memory completion.
REQ-019 io_in  input  16  IO input port; io_out  output  16  IO output register; io_stb  output  1  one-cycle pulse on IO write.
REQ-020 irq_in  input  4  interrupt sources, level, bit 0 highest priority.

Function
REQ-021 FSM states: IDLE, MEM, IO, INTA, DONE; SHALL leave IDLE only when cpu_req or cpu_intreq is 1.
REQ-022 In IDLE, cpu_intreq=1 SHALL win over simultaneous cpu_req (-> INTA); cpu_req then stays held and is accepted on return to IDLE.
REQ-023 IDLE, cpu_req=1, cpu_ioe=0 -> MEM: next edge drives mem_addr=cpu_addr, mem_wdata=cpu_do, mem_we=cpu_wrmem, mem_re=~cpu_wrmem.
REQ-024 MEM SHALL hold strobes and count cycles; on mem_ack=1 SHALL drop strobes, latch mem_rdata into cpu_di (reads only), go DONE.
REQ-025 MEM with no mem_ack after TIMEOUT strobe cycles SHALL drop strobes, set cpu_di=16'hFFFF, pulse bus_err with cpu_ready, go DONE.
REQ-026 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success, no bus_err.
REQ-027 IDLE, cpu_req=1, cpu_ioe=1 -> IO: write loads io_out=cpu_do and pulses io_stb; read loads cpu_di=io_in; address ignored.
REQ-028 INTA SHALL select lowest-indexed pending bit n, set cpu_di=IRQ_BASE+4*n, clear bit n; no pending bit -> cpu_di=16'h0000 (spurious).
REQ-029 DONE SHALL assert cpu_ready for exactly one cycle and return to IDLE; cpu_ready never asserted in two consecutive cycles.
REQ-030 Latency: IO/INTA cpu_ready 2 cycles after acceptance edge; MEM cpu_ready 1 cycle after edge sampling mem_ack.
REQ-031 pending[3:0] SHALL OR irq_in every cycle; set by irq_in SHALL win over simultaneous INTA clear of the same bit.
REQ-032 cpu_di SHALL hold its value between transfers; writes SHALL not change cpu_di.
REQ-033 mem_ack outside MEM SHALL be ignored.

Reset
REQ-034 rst=1 SHALL force IDLE, cpu_di=0, cpu_ready=0, cpu_irq=0, bus_err=0, mem_addr=0, mem_wdata=0, mem_re=0, mem_we=0, io_out=0, io_stb=0, pending=0, counter=0 at the next edge.
REQ-035 rst mid-transfer SHALL abandon it with no cpu_ready, no bus_err, strobes low after that edge.

Verification
REQ-036 Mem read: cpu_req, addr 16'h0040, wrmem=0, ioe=0; mem_ack with rdata 16'hBEEF 2 cycles later -> mem_re high until ack, cpu_di=16'hBEEF, one cpu_ready pulse.
REQ-037 Timeout: mem write, mem_ack never -> mem_we high 8 cycles, cpu_ready and bus_err pulse together, cpu_di=16'hFFFF.
REQ-038 IO: write cpu_do=16'h1234 -> io_out=16'h1234, one io_stb; then read io_in=16'h00A5 -> cpu_di=16'h00A5.
REQ-039 Interrupt: irq_in=4'b1010 pulse, cpu_irq=1; two INTA -> vectors 16'h0024 then 16'h002C, cpu_irq=0 after; third INTA -> 16'h0000.
REQ-040 Priority/reset: cpu_req and cpu_intreq same cycle -> INTA completes first, then transfer; rst in MEM -> strobes low next cycle, no cpu_ready.
